// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } arb_state_t;

  localparam int unsigned TIMEOUT_CYC_DEF = 255;
  localparam int unsigned WDOG_W          = 16;
  // Read data returned on an aborted access; decodes as a NOP for fetch.
  localparam logic [31:0] ABORT_RDATA     = 32'h0000_0000;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline + backing-memory signal bundle. slave = arbiter view, master = environment view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              dm_read_i;
  logic              dm_write_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              err_o;

  modport slave (
    input  if_req_i, if_addr_i, dm_read_i, dm_write_i, dm_addr_i, dm_wdata_i,
    input  mem_ack_i, mem_rdata_i,
    output if_rdata_o, dm_rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o,
    output mem_wdata_o, err_o
  );

  modport master (
    output if_req_i, if_addr_i, dm_read_i, dm_write_i, dm_addr_i, dm_wdata_i,
    output mem_ack_i, mem_rdata_i,
    input  if_rdata_o, dm_rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o,
    input  mem_wdata_o, err_o
  );
endinterface

// File: rtl/arb_watchdog.sv
// Counts BUSY cycles without acknowledge and pulses expire_c on the last allowed one.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  logic [WDOG_W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + WDOG_W'(1);
    end
  end

  // Fires during the TIMEOUT_CYC-th unacknowledged BUSY cycle.
  assign expire_c = enable && (cnt == WDOG_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF-stage fetches and MEM-stage data accesses onto one memory port
// and stalls the whole pipeline until every active request has been served.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic             clk_i,
  input logic             rst_i,
  mem_port_arbiter_if.slave bus
);

  arb_state_t        state;
  logic              if_done;
  logic              dm_done;
  logic              dm_act;
  logic              dm_pend;
  logic              if_pend;
  logic              stall;
  logic              busy;
  logic              wd_expire;
  logic              mem_req;
  logic              mem_we;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] if_rdata;
  logic [DATA_W-1:0] dm_rdata;

  assign dm_act  = bus.dm_read_i | bus.dm_write_i;
  assign dm_pend = dm_act & ~dm_done;
  assign if_pend = bus.if_req_i & ~if_done;
  assign stall   = dm_pend | if_pend;
  assign busy    = (state != IDLE);

  arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (~busy),
    .enable  (busy & ~bus.mem_ack_i),
    .expire_c(wd_expire)
  );

  // Arbitration FSM with done flags and captured read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Pipeline advances on this edge; both requests are new next cycle.
          if (!stall) begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
          end
          // Data access belongs to the older instruction, so it goes first.
          if (dm_pend) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= bus.dm_write_i;
            mem_addr  <= bus.dm_addr_i;
            mem_wdata <= bus.dm_wdata_i;
          end else if (if_pend) begin
            state    <= BUSY_I;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= bus.if_addr_i;
          end
        end
        BUSY_D: begin
          if (bus.mem_ack_i) begin
            if (!mem_we) begin
              dm_rdata <= bus.mem_rdata_i;
            end
            dm_done <= 1'b1;
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (wd_expire) begin
            dm_rdata <= DATA_W'(ABORT_RDATA);
            err      <= 1'b1;
            dm_done  <= 1'b1;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end
        end
        BUSY_I: begin
          if (bus.mem_ack_i) begin
            if_rdata <= bus.mem_rdata_i;
            if_done  <= 1'b1;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end else if (wd_expire) begin
            if_rdata <= DATA_W'(ABORT_RDATA);
            err      <= 1'b1;
            if_done  <= 1'b1;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall_o     = stall;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;
  assign bus.if_rdata_o  = if_rdata;
  assign bus.dm_rdata_o  = dm_rdata;
  assign bus.err_o       = err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural memory responder plus directed and random steps.
module tb_mem_port_arbiter;

  localparam int TO     = 4;
  localparam int NO_ACK = 1000;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int stab_err = 0;
  int gap_err = 0;
  int proto_err = 0;
  txn_t log_q[$];
  int waitq[$];
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Variable-latency backing memory: ack after the queued number of wait states.
  initial begin
    int cyc;
    int cur_wait;
    logic expect_low;
    txn_t cur;
    for (int a = 0; a < 256; a += 4) mem[32'(a)] = $urandom;
    mem[32'h10] = 32'h2008_0005;
    mem[32'h40] = 32'h1234_5678;
    mem[32'h14] = 32'hAC09_0000;
    mem[32'h20] = 32'h1111_2222;
    mem[32'h24] = 32'h3333_4444;
    mem[32'h44] = 32'h55AA_1234;
    mem[32'h00] = 32'h0000_0013;
    mem[32'h04] = 32'h0010_0093;
    mem[32'h08] = 32'h0020_0113;
    cyc = 0; cur_wait = 0; expect_low = 1'b0; cur = '0;
    bus.mem_ack_i = 1'b0;
    bus.mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; expect_low = 1'b0; bus.mem_ack_i = 1'b0;
      end else if (bus.mem_req_o) begin
        if (expect_low) gap_err++;
        cyc++;
        if (cyc == 1) begin
          cur_wait = (waitq.size() > 0) ? waitq.pop_front() : 0;
          cur = '{we: bus.mem_we_o, addr: bus.mem_addr_o, wdata: bus.mem_wdata_o};
          log_q.push_back(cur);
        end else if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== cur) begin
          stab_err++;
        end
        if (cyc == cur_wait + 1) begin
          bus.mem_ack_i = 1'b1;
          if (cur.we) begin
            mem[cur.addr] = cur.wdata;
            bus.mem_rdata_i = 32'hDEAD_BEEF;
          end else begin
            bus.mem_rdata_i = mem_rd(cur.addr);
          end
          expect_low = 1'b1;
        end else begin
          bus.mem_ack_i = 1'b0;
          bus.mem_rdata_i = $urandom;
          expect_low = (cyc == TO);
        end
      end else begin
        // Idle: spurious acks with junk data must be ignored.
        cyc = 0; expect_low = 1'b0;
        bus.mem_ack_i = 1'($urandom_range(0, 1));
        bus.mem_rdata_i = $urandom;
      end
    end
  end

  // Pipeline protocol monitor: requests must not move while stalled.
  initial begin
    logic p_stall;
    logic [97:0] p_req;
    p_stall = 1'b0; p_req = '0;
    forever begin
      @(posedge clk);
      if (!rst && p_stall && ({bus.dm_read_i, bus.dm_write_i, bus.if_req_i, bus.dm_addr_i,
          bus.dm_wdata_i, bus.if_addr_i[31:1]} !== p_req)) proto_err++;
      p_stall = bus.stall_o;
      p_req = {bus.dm_read_i, bus.dm_write_i, bus.if_req_i, bus.dm_addr_i, bus.dm_wdata_i,
               bus.if_addr_i[31:1]};
    end
  end

  task automatic clear_inputs();
    bus.dm_read_i = 1'b0; bus.dm_write_i = 1'b0; bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
    bus.if_req_i = 1'b0; bus.if_addr_i = '0;
  endtask

  // Drive one pipeline step, count stalled cycles, return read data on the release cycle.
  task automatic do_step(input logic rd, input logic wr, input logic [31:0] da,
                         input logic [31:0] wd, input logic ireq, input logic [31:0] ia,
                         output int sc, output logic [31:0] ir, output logic [31:0] dr);
    bus.dm_read_i = rd; bus.dm_write_i = wr; bus.dm_addr_i = da; bus.dm_wdata_i = wd;
    bus.if_req_i = ireq; bus.if_addr_i = ia;
    sc = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.stall_o) sc++;
      else break;
    end
    if (bus.stall_o) begin
      errors++;
      $display("FAIL step_hang stall still high after %0d cycles", sc);
    end
    ir = bus.if_rdata_o;
    dr = bus.dm_rdata_o;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", bus.mem_req_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", bus.mem_we_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err_o); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall_o); end
    checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", bus.mem_addr_o); end
    checks++; if (bus.mem_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", bus.mem_wdata_o); end
    checks++; if (bus.if_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_if_rdata got %h exp 0", bus.if_rdata_o); end
    checks++; if (bus.dm_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_dm_rdata got %h exp 0", bus.dm_rdata_o); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_lone_fetch();
    int sc; logic [31:0] ir, dr; int n0;
    n0 = log_q.size();
    waitq.push_back(0);
    do_step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h10, sc, ir, dr);
    checks++; if (sc !== 2) begin errors++; $display("FAIL fetch_stall_cycles got %0d exp 2", sc); end
    checks++; if (ir !== 32'h2008_0005) begin errors++; $display("FAIL fetch_rdata got %h exp 20080005", ir); end
    checks++; if (log_q.size() !== n0 + 1) begin errors++; $display("FAIL fetch_txn_count got %0d exp %0d", log_q.size(), n0 + 1); end
    else begin
      checks++;
      if (log_q[n0].we !== 1'b0 || log_q[n0].addr !== 32'h10) begin
        errors++; $display("FAIL fetch_txn got we=%b addr=%h exp we=0 addr=10", log_q[n0].we, log_q[n0].addr);
      end
    end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL fetch_stability got %0d exp 0", stab_err); end
  endtask

  task automatic test_fetch_load();
    int sc; logic [31:0] ir, dr; int n0;
    n0 = log_q.size();
    waitq.push_back(0); waitq.push_back(0);
    do_step(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'h14, sc, ir, dr);
    checks++; if (sc !== 4) begin errors++; $display("FAIL dual_stall_cycles got %0d exp 4", sc); end
    checks++; if (dr !== 32'h1234_5678) begin errors++; $display("FAIL dual_dm_rdata got %h exp 12345678", dr); end
    checks++; if (ir !== 32'hAC09_0000) begin errors++; $display("FAIL dual_if_rdata got %h exp ac090000", ir); end
    checks++; if (log_q.size() !== n0 + 2) begin errors++; $display("FAIL dual_txn_count got %0d exp %0d", log_q.size(), n0 + 2); end
    else begin
      checks++;
      if (log_q[n0].addr !== 32'h40 || log_q[n0 + 1].addr !== 32'h14) begin
        errors++; $display("FAIL dual_order got %h,%h exp 40,14", log_q[n0].addr, log_q[n0 + 1].addr);
      end
    end
    checks++; if (gap_err !== 0) begin errors++; $display("FAIL dual_idle_gap got %0d exp 0", gap_err); end
  endtask

  task automatic test_store_wait();
    int sc; logic [31:0] ir, dr; int n0;
    n0 = log_q.size();
    waitq.push_back(3);
    do_step(1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, 1'b0, 32'h0, sc, ir, dr);
    checks++; if (sc !== 5) begin errors++; $display("FAIL store_stall_cycles got %0d exp 5", sc); end
    checks++; if (dr !== 32'h1234_5678) begin errors++; $display("FAIL store_dm_rdata got %h exp 12345678", dr); end
    checks++; if (log_q.size() !== n0 + 1) begin errors++; $display("FAIL store_txn_count got %0d exp %0d", log_q.size(), n0 + 1); end
    else begin
      checks++;
      if (log_q[n0] !== '{we: 1'b1, addr: 32'h80, wdata: 32'hCAFE_F00D}) begin
        errors++; $display("FAIL store_txn got we=%b addr=%h wdata=%h exp 1/80/cafef00d", log_q[n0].we, log_q[n0].addr, log_q[n0].wdata);
      end
    end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL store_stability got %0d exp 0", stab_err); end
    checks++; if (mem_rd(32'h80) !== 32'hCAFE_F00D) begin errors++; $display("FAIL store_mem got %h exp cafef00d", mem_rd(32'h80)); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL store_ack_at_limit_err got %b exp 0", bus.err_o); end
  endtask

  task automatic test_timeout();
    int sc; logic [31:0] ir, dr; int n0;
    n0 = log_q.size();
    waitq.push_back(NO_ACK);
    do_step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h20, sc, ir, dr);
    checks++; if (sc !== 1 + TO) begin errors++; $display("FAIL timeout_stall_cycles got %0d exp %0d", sc, 1 + TO); end
    checks++; if (ir !== 32'h0) begin errors++; $display("FAIL timeout_if_rdata got %h exp 0", ir); end
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL timeout_err got %b exp 1", bus.err_o); end
    checks++; if (gap_err !== 0) begin errors++; $display("FAIL timeout_req_drop got %0d exp 0", gap_err); end
    checks++; if (log_q.size() !== n0 + 1) begin errors++; $display("FAIL timeout_txn_count got %0d exp %0d", log_q.size(), n0 + 1); end
    waitq.push_back(0);
    do_step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h24, sc, ir, dr);
    checks++; if (sc !== 2) begin errors++; $display("FAIL after_timeout_stall got %0d exp 2", sc); end
    checks++; if (ir !== 32'h3333_4444) begin errors++; $display("FAIL after_timeout_rdata got %h exp 33334444", ir); end
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", bus.err_o); end
  endtask

  task automatic test_reset_mid_busy();
    int sc; int n0;
    n0 = log_q.size();
    waitq.push_back(NO_ACK); waitq.push_back(0);
    bus.dm_read_i = 1'b1; bus.dm_addr_i = 32'h44;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL mid_busy_req got %b exp 1", bus.mem_req_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_busy_req got %b exp 0", bus.mem_req_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rst_busy_err got %b exp 0", bus.err_o); end
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL rst_busy_stall got %b exp 1", bus.stall_o); end
    sc = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.stall_o) sc++;
      else break;
    end
    checks++; if (sc !== 2) begin errors++; $display("FAIL reissue_stall got %0d exp 2", sc); end
    checks++; if (bus.dm_rdata_o !== 32'h55AA_1234) begin errors++; $display("FAIL reissue_rdata got %h exp 55aa1234", bus.dm_rdata_o); end
    checks++; if (log_q.size() !== n0 + 2) begin errors++; $display("FAIL reissue_txn_count got %0d exp %0d", log_q.size(), n0 + 2); end
    else begin
      checks++;
      if (log_q[n0 + 1].addr !== 32'h44) begin errors++; $display("FAIL reissue_addr got %h exp 44", log_q[n0 + 1].addr); end
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int sc; logic [31:0] ir, dr; int n0;
    logic [31:0] exp_ir [3];
    exp_ir[0] = 32'h0000_0013; exp_ir[1] = 32'h0010_0093; exp_ir[2] = 32'h0020_0113;
    n0 = log_q.size();
    for (int i = 0; i < 3; i++) begin
      waitq.push_back(1);
      do_step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'(i * 4), sc, ir, dr);
      checks++; if (sc !== 3) begin errors++; $display("FAIL b2b_stall[%0d] got %0d exp 3", i, sc); end
      checks++; if (ir !== exp_ir[i]) begin errors++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i, ir, exp_ir[i]); end
    end
    checks++; if (log_q.size() !== n0 + 3) begin errors++; $display("FAIL b2b_txn_count got %0d exp %0d", log_q.size(), n0 + 3); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (log_q[n0 + i].addr !== 32'(i * 4)) begin errors++; $display("FAIL b2b_addr[%0d] got %h exp %h", i, log_q[n0 + i].addr, 32'(i * 4)); end
      end
    end
  endtask

  task automatic test_random();
    int sc; int exp_sc; logic [31:0] ir, dr;
    logic [31:0] exp_ir, exp_dr; logic exp_err;
    logic rd, wr, ireq, to_d, to_i; int w_d, w_i;
    logic [31:0] da, wd, ia;
    exp_ir = 32'h0020_0113; exp_dr = 32'h55AA_1234; exp_err = 1'b0;
    for (int s = 0; s < 60; s++) begin
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) == 0);
      ireq = 1'($urandom_range(0, 1));
      da = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      ia = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      wd = $urandom;
      w_d = $urandom_range(0, 3); w_i = $urandom_range(0, 3);
      to_d = !wr && ($urandom_range(0, 7) == 0);
      to_i = ($urandom_range(0, 7) == 0);
      exp_sc = 0;
      // Data access is served before the fetch; a store is visible to the following fetch.
      if (rd || wr) begin
        waitq.push_back(to_d ? NO_ACK : w_d);
        exp_sc += 1 + (to_d ? TO : w_d + 1);
        if (!wr) exp_dr = to_d ? 32'h0 : mem_rd(da);
        if (to_d) exp_err = 1'b1;
      end
      if (ireq) begin
        waitq.push_back(to_i ? NO_ACK : w_i);
        exp_sc += 1 + (to_i ? TO : w_i + 1);
        exp_ir = to_i ? 32'h0 : ((wr && da == ia) ? wd : mem_rd(ia));
        if (to_i) exp_err = 1'b1;
      end
      do_step(rd, wr, da, wd, ireq, ia, sc, ir, dr);
      checks++; if (sc !== exp_sc) begin errors++; $display("FAIL rnd_stall[%0d] got %0d exp %0d", s, sc, exp_sc); end
      checks++; if (ir !== exp_ir) begin errors++; $display("FAIL rnd_if_rdata[%0d] got %h exp %h", s, ir, exp_ir); end
      checks++; if (dr !== exp_dr) begin errors++; $display("FAIL rnd_dm_rdata[%0d] got %h exp %h", s, dr, exp_dr); end
      checks++; if (bus.err_o !== exp_err) begin errors++; $display("FAIL rnd_err[%0d] got %b exp %b", s, bus.err_o, exp_err); end
    end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL rnd_stability got %0d exp 0", stab_err); end
    checks++; if (gap_err !== 0) begin errors++; $display("FAIL rnd_idle_gap got %0d exp 0", gap_err); end
    checks++; if (proto_err !== 0) begin errors++; $display("FAIL pipeline_protocol got %0d exp 0", proto_err); end
    checks++; if (waitq.size() !== 0) begin errors++; $display("FAIL unserved_txns got %0d exp 0", waitq.size()); end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_fetch_load();
    test_store_wait();
    test_timeout();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
